// File: rtl/velmshift_seq_pkg.sv
// Shared definitions for the element-shifter sequencer: state encoding,
// default geometry and a step-count helper.
package velmshift_seq_pkg;

    localparam int unsigned NUMLANES_DEF = 4;
    localparam int unsigned WIDTH_DEF    = 32;
    localparam int unsigned JUMPSIZE_DEF = 2;
    localparam int unsigned CNTW_DEF     = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STEP   = 2'd2,
        ST_RESULT = 2'd3
    } state_e;

    // Number of shift cycles (jumps first, then single steps) for a slide.
    function automatic int unsigned step_count(input int unsigned amount,
                                               input int unsigned numlanes,
                                               input int unsigned jumpsize);
        int unsigned n;
        n = (amount > numlanes) ? numlanes : amount;
        return (n / jumpsize) + (n % jumpsize);
    endfunction

endpackage

// File: rtl/velmshift_seq_if.sv
// Command / result handshake bundle for the element-shifter sequencer.
interface velmshift_seq_if #(
    parameter int unsigned NUMLANES = 4,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CNTW     = 3
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_dir_left;
    logic [CNTW-1:0]           cmd_amount;
    logic [NUMLANES-1:0]       cmd_mask;
    logic [NUMLANES*WIDTH-1:0] cmd_data;
    logic                      res_valid;
    logic                      res_ready;
    logic [NUMLANES*WIDTH-1:0] res_data;

    modport slave (
        input  cmd_valid, cmd_dir_left, cmd_amount, cmd_mask, cmd_data, res_ready,
        output cmd_ready, res_valid, res_data
    );

    modport master (
        output cmd_valid, cmd_dir_left, cmd_amount, cmd_mask, cmd_data, res_ready,
        input  cmd_ready, res_valid, res_data
    );
endinterface

// File: rtl/velmshift_seq_stepgen.sv
// Remaining-distance counter: loads the clamped slide distance and decides,
// per step, whether a jump or a single-lane move is issued.
module velmshift_stepgen
    import velmshift_seq_pkg::*;
#(
    parameter int unsigned NUMLANES = NUMLANES_DEF,
    parameter int unsigned JUMPSIZE = JUMPSIZE_DEF,
    parameter int unsigned CNTW     = CNTW_DEF
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            i_load,
    input  logic [CNTW-1:0] i_amount,
    input  logic            i_step,
    output logic            o_rem_zero,
    output logic            o_jump,
    output logic            o_last
);
    localparam logic [CNTW-1:0] LP_LANES = CNTW'(NUMLANES);
    localparam logic [CNTW-1:0] LP_JUMP  = CNTW'(JUMPSIZE);
    localparam logic [CNTW-1:0] LP_ONE   = CNTW'(1);
    localparam logic [CNTW-1:0] LP_ZERO  = CNTW'(0);

    logic [CNTW-1:0] r_rem;
    logic [CNTW-1:0] w_clamped;
    logic [CNTW-1:0] w_dec;

    // Clamp the requested distance and pick this step's decrement.
    always_comb begin
        w_clamped = i_amount;
        w_dec     = LP_ONE;
        o_jump    = 1'b0;
        if (i_amount > LP_LANES) begin
            w_clamped = LP_LANES;
        end else begin
            w_clamped = i_amount;
        end
        if (r_rem >= LP_JUMP) begin
            o_jump = 1'b1;
            w_dec  = LP_JUMP;
        end else begin
            o_jump = 1'b0;
            w_dec  = LP_ONE;
        end
        o_rem_zero = (r_rem == LP_ZERO);
        o_last     = (r_rem == w_dec);
    end

    // Remaining-distance register: load on accept, count down per step.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rem <= LP_ZERO;
        end else if (i_load) begin
            r_rem <= w_clamped;
        end else if (i_step) begin
            r_rem <= r_rem - w_dec;
        end else begin
            r_rem <= r_rem;
        end
    end

endmodule

// File: rtl/velmshift_seq.sv
// Sequencer for the jump-capable element shifter: accepts a slide command,
// loads the shifter, issues jumps then single steps, and presents the
// shifter contents as the result.
module velmshift_seq
    import velmshift_seq_pkg::*;
#(
    parameter int unsigned NUMLANES = NUMLANES_DEF,
    parameter int unsigned WIDTH    = WIDTH_DEF,
    parameter int unsigned JUMPSIZE = JUMPSIZE_DEF,
    parameter int unsigned CNTW     = CNTW_DEF
) (
    input  logic                      clk,
    input  logic                      resetn,
    velmshift_seq_if.slave            bus,
    output logic                      shf_load,
    output logic                      shf_shift,
    output logic                      shf_jump,
    output logic                      shf_dir_left,
    output logic [NUMLANES-1:0]       shf_squash,
    output logic [WIDTH-1:0]          shf_shiftin_left,
    output logic [WIDTH-1:0]          shf_shiftin_right,
    output logic [NUMLANES*WIDTH-1:0] shf_inpipe,
    input  logic [NUMLANES*WIDTH-1:0] shf_outpipe,
    output logic                      busy
);
    state_e                    r_state;
    state_e                    w_state_nxt;
    logic                      r_dir;
    logic [NUMLANES-1:0]       r_mask;
    logic [NUMLANES*WIDTH-1:0] r_data;
    logic                      w_accept;
    logic                      w_step;
    logic                      w_rem_zero;
    logic                      w_jump;
    logic                      w_last;

    velmshift_stepgen #(
        .NUMLANES (NUMLANES),
        .JUMPSIZE (JUMPSIZE),
        .CNTW     (CNTW)
    ) u_stepgen (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (w_accept),
        .i_amount   (bus.cmd_amount),
        .i_step     (w_step),
        .o_rem_zero (w_rem_zero),
        .o_jump     (w_jump),
        .o_last     (w_last)
    );

    // Next-state and shifter controls, decoded from state and remaining count.
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_step        = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.res_valid = 1'b0;
        shf_load      = 1'b0;
        shf_shift     = 1'b0;
        shf_jump      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                shf_load = 1'b1;
                if (w_rem_zero) begin
                    w_state_nxt = ST_RESULT;
                end else begin
                    w_state_nxt = ST_STEP;
                end
            end
            ST_STEP: begin
                // A zero count here is unreachable; leave without shifting.
                if (w_rem_zero) begin
                    w_state_nxt = ST_RESULT;
                end else begin
                    shf_shift = 1'b1;
                    shf_jump  = w_jump;
                    w_step    = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_RESULT;
                    end else begin
                        w_state_nxt = ST_STEP;
                    end
                end
            end
            ST_RESULT: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESULT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Direction and squash follow the captured command outside IDLE.
    always_comb begin
        shf_dir_left = 1'b0;
        shf_squash   = '0;
        if (r_state != ST_IDLE) begin
            shf_dir_left = r_dir;
            shf_squash   = r_mask;
        end else begin
            shf_dir_left = 1'b0;
            shf_squash   = '0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command capture on the accepting handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dir  <= 1'b0;
            r_mask <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_dir  <= bus.cmd_dir_left;
            r_mask <= bus.cmd_mask;
            r_data <= bus.cmd_data;
        end else begin
            r_dir  <= r_dir;
            r_mask <= r_mask;
            r_data <= r_data;
        end
    end

    assign shf_inpipe        = r_data;
    assign shf_shiftin_left  = '0;
    assign shf_shiftin_right = '0;
    assign bus.res_data      = shf_outpipe;
    assign busy              = (r_state != ST_IDLE);

endmodule

// File: tb/tb_velmshift_seq.sv
// Self-checking bench for velmshift_seq with a behavioural shifter model.
module tb_velmshift_seq;
    localparam int NL = 4;
    localparam int W  = 32;
    localparam int LW = NL * W;

    logic clk;
    logic resetn;
    logic shf_load, shf_shift, shf_jump, shf_dir_left, busy;
    logic [NL-1:0] shf_squash;
    logic [W-1:0]  shf_shiftin_left, shf_shiftin_right;
    logic [LW-1:0] shf_inpipe, shf_outpipe, sh_q;

    int n_total = 0;
    int n_pass  = 0;

    velmshift_seq_if #(.NUMLANES(NL), .WIDTH(W), .CNTW(3)) u_if ();

    velmshift_seq #(.NUMLANES(NL), .WIDTH(W), .JUMPSIZE(2), .CNTW(3)) u_dut (
        .clk               (clk),
        .resetn            (resetn),
        .bus               (u_if),
        .shf_load          (shf_load),
        .shf_shift         (shf_shift),
        .shf_jump          (shf_jump),
        .shf_dir_left      (shf_dir_left),
        .shf_squash        (shf_squash),
        .shf_shiftin_left  (shf_shiftin_left),
        .shf_shiftin_right (shf_shiftin_right),
        .shf_inpipe        (shf_inpipe),
        .shf_outpipe       (shf_outpipe),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural element shifter (jump = 2 lanes), sharing the reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sh_q <= '0;
        else if (shf_load) sh_q <= shf_inpipe;
        else if (shf_shift) begin
            if (shf_dir_left) sh_q <= shf_jump ? (sh_q << 64) : (sh_q << 32);
            else              sh_q <= shf_jump ? (sh_q >> 64) : (sh_q >> 32);
        end
    end
    assign shf_outpipe = sh_q;

    task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference: lanes slide by min(amount, NL) with zero fill.
    function automatic logic [LW-1:0] ref_slide(input logic dir, input int n, input logic [LW-1:0] d);
        return dir ? (d << (W * n)) : (d >> (W * n));
    endfunction

    typedef struct {
        logic          dir;
        logic [2:0]    amt;
        logic [NL-1:0] mask;
        logic [LW-1:0] data;
        logic [LW-1:0] exp;
        int            stall;
        bit            pulse;
    } vec_t;

    task automatic run_cmd(input string nm, input vec_t v);
        int n, exp_k, exp_j, cyc, load_cyc, loads, steps, jumps, first_step, res_cyc;
        bit seen, both, ctl_bad, stall_bad;
        n = (int'(v.amt) > NL) ? NL : int'(v.amt);
        exp_j = n / 2;
        exp_k = exp_j + (n % 2);
        load_cyc = 0; loads = 0; steps = 0; jumps = 0; first_step = 0; res_cyc = 0;
        seen = 0; both = 0; ctl_bad = 0; stall_bad = 0;
        @(negedge clk);
        u_if.cmd_valid = 1'b1; u_if.cmd_dir_left = v.dir; u_if.cmd_amount = v.amt;
        u_if.cmd_mask = v.mask; u_if.cmd_data = v.data; u_if.res_ready = 1'b0;
        check({nm, " cmd_ready"}, LW'(u_if.cmd_ready), LW'(1));
        @(negedge clk);
        u_if.cmd_valid = 1'b0;
        cyc = 1;
        while (cyc <= 20 && !seen) begin
            if (u_if.res_valid) begin
                seen = 1; res_cyc = cyc;
            end else begin
                if (shf_load) begin loads++; load_cyc = cyc; end
                if (shf_shift) begin
                    steps++;
                    if (shf_jump) jumps++;
                    if (first_step == 0) first_step = cyc;
                end
                if (shf_load && shf_shift) both = 1;
                if (shf_squash !== v.mask || shf_dir_left !== v.dir || busy !== 1'b1) ctl_bad = 1;
                @(negedge clk);
                cyc++;
            end
        end
        check({nm, " res_seen"}, LW'(seen), LW'(1));
        check({nm, " load_cycle"}, LW'(load_cyc), LW'(1));
        check({nm, " load_count"}, LW'(loads), LW'(1));
        check({nm, " steps"}, LW'(steps), LW'(exp_k));
        check({nm, " jumps"}, LW'(jumps), LW'(exp_j));
        check({nm, " first_step"}, LW'(first_step), LW'((exp_k > 0) ? 2 : 0));
        check({nm, " res_cycle"}, LW'(res_cyc), LW'(2 + exp_k));
        check({nm, " res_data"}, u_if.res_data, v.exp);
        check({nm, " load_and_shift"}, LW'(both), LW'(0));
        check({nm, " ctl_busy"}, LW'(ctl_bad), LW'(0));
        for (int s = 0; s < v.stall; s++) begin
            if (u_if.res_valid !== 1'b1 || u_if.res_data !== v.exp || shf_load || shf_shift
                || shf_squash !== v.mask || shf_dir_left !== v.dir) stall_bad = 1;
            if (v.pulse && s == 3) begin
                u_if.cmd_valid = 1'b1; u_if.cmd_amount = 3'd1; u_if.cmd_data = ~v.data;
                check({nm, " ready_in_stall"}, LW'(u_if.cmd_ready), LW'(0));
            end
            if (v.pulse && s == 4) u_if.cmd_valid = 1'b0;
            @(negedge clk);
        end
        if (v.stall > 0) check({nm, " stall_stable"}, LW'(stall_bad), LW'(0));
        u_if.res_ready = 1'b1;
        @(negedge clk);
        u_if.res_ready = 1'b0;
        check({nm, " ready_after"}, LW'({u_if.cmd_ready, busy, u_if.res_valid, shf_load,
                                         shf_dir_left, shf_squash}), LW'({1'b1, 8'h00}));
    endtask

    vec_t vecs[6];
    logic [LW-1:0] d0;
    vec_t rv;

    initial begin
        d0 = {32'h44, 32'h33, 32'h22, 32'h11};
        vecs[0] = '{1'b1, 3'd3, 4'b0000, d0, {32'h11, 32'h0, 32'h0, 32'h0}, 0, 1'b0};
        vecs[1] = '{1'b0, 3'd2, 4'b0000, d0, {32'h0, 32'h0, 32'h44, 32'h33}, 0, 1'b0};
        vecs[2] = '{1'b1, 3'd0, 4'b0000, d0, d0, 0, 1'b0};
        vecs[3] = '{1'b0, 3'd7, 4'b0000, d0, '0, 0, 1'b0};
        vecs[4] = '{1'b1, 3'd1, 4'b0000, d0, {32'h33, 32'h22, 32'h11, 32'h0}, 10, 1'b1};
        vecs[5] = '{1'b0, 3'd1, 4'b1010, d0, {32'h0, 32'h44, 32'h33, 32'h22}, 2, 1'b0};

        resetn = 1'b0;
        u_if.cmd_valid = 1'b0; u_if.cmd_dir_left = 1'b0; u_if.cmd_amount = 3'd0;
        u_if.cmd_mask = '0; u_if.cmd_data = '0; u_if.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", LW'({u_if.cmd_ready, busy, u_if.res_valid, shf_load, shf_shift,
                                  shf_jump, shf_dir_left, shf_squash}), LW'({1'b1, 10'h000}));
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) run_cmd($sformatf("vec%0d", i), vecs[i]);

        // Reset asserted in the middle of a 4-lane slide.
        @(negedge clk);
        u_if.cmd_valid = 1'b1; u_if.cmd_dir_left = 1'b1; u_if.cmd_amount = 3'd4;
        u_if.cmd_mask = 4'b0110; u_if.cmd_data = d0;
        @(negedge clk);
        u_if.cmd_valid = 1'b0;
        @(negedge clk);
        check("midstep_shift", LW'(shf_shift), LW'(1));
        resetn = 1'b0;
        #1;
        check("midstep_reset", LW'({u_if.cmd_ready, busy, u_if.res_valid, shf_load, shf_shift,
                                    shf_jump, shf_dir_left, shf_squash}), LW'({1'b1, 10'h000}));
        @(negedge clk);
        check("midstep_reset_hold", LW'({u_if.cmd_ready, busy, shf_shift}), LW'(3'b100));
        resetn = 1'b1;
        run_cmd("after_reset", vecs[0]);

        // Randomised commands against the reference slide.
        for (int r = 0; r < 30; r++) begin
            rv.dir   = 1'($urandom);
            rv.amt   = 3'($urandom_range(0, 7));
            rv.mask  = 4'($urandom);
            rv.data  = {$urandom, $urandom, $urandom, $urandom};
            rv.exp   = ref_slide(rv.dir, (int'(rv.amt) > NL) ? NL : int'(rv.amt), rv.data);
            rv.stall = int'($urandom_range(0, 3));
            rv.pulse = 1'b0;
            run_cmd($sformatf("rand%0d", r), rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/velmshift_seq.md
Name: velmshift_seq

Overview:
- Sequencer that sits directly upstream of the jump-capable element shifter (velmshifter_jump, NUMLANES x WIDTH).
- Accepts a vector slide command by valid/ready: packed lane data, slide distance, direction and lane squash mask.
- Drives the shifter's load/shift/jump/dir_left/squash controls, using as many jumps as possible, then single steps.
- Returns the shifter's final outpipe as a result by valid/ready.

Parameters:
- NUMLANES, 4, lanes in the shifter.
- WIDTH, 32, bits per lane.
- JUMPSIZE, 2, lanes moved by one jump step. Must match the shifter instance.
- CNTW, 3, width of the distance field. Must satisfy 2^CNTW > NUMLANES.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_dir_left  in  1  1 = slide toward lane NUMLANES-1, 0 = toward lane 0
- cmd_amount  in  CNTW  slide distance in lanes
- cmd_mask  in  NUMLANES  per-lane squash applied for the whole operation
- cmd_data  in  NUMLANES*WIDTH  packed lanes, lane 0 in the LSBs
- shf_load  out  1  shifter load
- shf_shift  out  1  shifter shift
- shf_jump  out  1  shifter jump (valid with shf_shift)
- shf_dir_left  out  1  shifter direction
- shf_squash  out  NUMLANES  shifter squash
- shf_shiftin_left  out  WIDTH  tied to 0
- shf_shiftin_right  out  WIDTH  tied to 0
- shf_inpipe  out  NUMLANES*WIDTH  shifter load data
- shf_outpipe  in  NUMLANES*WIDTH  shifter contents
- res_valid  out  1  result present
- res_ready  in  1  consumer accepts result
- res_data  out  NUMLANES*WIDTH  slid vector
- busy  out  1  high in every state except IDLE

Behaviour:
- Interface: one clock, clk. Reset resetn is asynchronous and active-low.
- On reset:
  - state = IDLE, remaining count = 0.
  - All registered fields are cleared.
  - cmd_ready=1, res_valid=0, busy=0.
  - shf_load, shf_shift, shf_jump, shf_dir_left are 0; shf_squash is 0.
- States: IDLE, LOAD, STEP, RESULT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready, register dir, mask and data, and register rem = min(cmd_amount, NUMLANES).
  - Next state is LOAD.
- LOAD: assert shf_load=1 for exactly one cycle, with shf_inpipe = registered data.
  - rem==0 -> RESULT.
  - Otherwise -> STEP.
- STEP, one command per cycle:
  - If rem >= JUMPSIZE: shf_shift=1, shf_jump=1, rem -= JUMPSIZE.
  - Else: shf_shift=1, shf_jump=0, rem -= 1.
  - When the issued step brings rem to 0 -> RESULT.
- RESULT:
  - res_valid=1; res_data = shf_outpipe.
  - No shifter controls are asserted, so the data stays stable.
  - On res_ready -> IDLE.
- shf_dir_left and shf_squash equal the registered dir and mask in LOAD, STEP and RESULT; 0 in IDLE.
- shf_inpipe equals the registered data at all times.
- Controls are combinational from state and rem only. There is no combinational path from cmd_* or res_ready to shf_*.
- Latency: with the command accepted at cycle T and k = floor(n/JUMPSIZE) + (n mod JUMPSIZE):
  - shf_load is high at T+1.
  - Steps occur at T+2 .. T+1+k.
  - res_valid rises at T+2+k.
- Boundaries:
  - Amount 0: no shift cycles; res_valid at T+2.
  - Amount > NUMLANES: clamped to NUMLANES, so the result is all zero lanes.
  - cmd_valid while busy: ignored (cmd_ready=0); the command must be held by the producer.
  - res_ready held low: stall indefinitely in RESULT with res_data stable.
  - Back-to-back: the next command can be accepted the cycle after RESULT handshakes. There is no overlap.
  - resetn asserted mid-operation: immediate return to reset values. The shifter, sharing the reset, clears too.
  - shf_load and shf_shift are never high in the same cycle.

Decomposition:
- Shared package holds:
  - The state encoding (IDLE=0, LOAD=1, STEP=2, RESULT=3).
  - The NUMLANES/JUMPSIZE defaults.
  - A constant function computing step count k, for bench checking.
- Natural sub-module: velmshift_stepgen. It holds the rem counter and the jump/single decision; the FSM wrapper owns the handshakes.

Test Plan:
- Reset mid-STEP (NUMLANES=4, WIDTH=32, JUMPSIZE=2): assert resetn=0 during a 4-lane slide -> next cycle busy=0, cmd_ready=1, res_valid=0, and all shf_* controls are 0.
- Left slide by 3: data={0x44,0x33,0x22,0x11} (lane3..lane0), mask=0, accept at T0.
  - Required: load at T1, jump at T2, single shift at T3.
  - Required: res_valid at T4, res_data={0x11,0,0,0}.
- Right slide by 2, same data: one jump at T2; res_valid at T3; res_data={0,0,0x44,0x33}.
- Amount 0, then amount 7:
  - Amount 0: res_valid at T2 with data unchanged.
  - Amount 7: clamped, with jump, jump issued; result is all zero at T4.
- Backpressure: res_ready=0 for 10 cycles after res_valid.
  - Required: res_data stable, no shf_load/shf_shift pulses.
  - Required: a cmd_valid pulsed during the stall is not accepted.
  - Required: after res_ready=1, cmd_ready returns the next cycle.
